thirty_two_bits_full_adder: RTL and testbench
=============================================

// Module: thirty_two_bits_full_adder
// PURPOSE
//   32-bit binary adder for the MIPS datapath (ALU add path, PC increment).
//   Computes s = a + b + c0 with a ripple-carry chain of 1-bit full adders.
//   Result and carry-out are registered, so the block is one pipeline stage.
// PARAMETERS
//   WIDTH  32  operand/result width; only 32 is supported and verified
// PORTS
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active-high
//   a     in   32     operand A, unsigned or two's complement
//   b     in   32     operand B, unsigned or two's complement
//   c0    in   1      carry-in; tie to 0 for plain add
//   s     out  32     registered sum bits [31:0]
//   cout  out  1      registered carry-out of bit 31
// BEHAVIOUR
//   - Reset: on a posedge with rst=1, s<=0 and cout<=0 (and ovf<=0 if built).
//     rst has priority over new operands.
//   - Normal operation: on each posedge with rst=0,
//     {cout,s} <= a + b + c0, a 33-bit exact sum.
//   - Latency: 1 cycle. Inputs sampled at edge N appear at outputs after edge N.
//     New operands are accepted every cycle; there is no handshake and no stall.
//   - Wrap-around: the sum is modulo 2^32, with the lost bit on cout.
//     Example: 0xFFFFFFFF + 0 + 1 -> s=0, cout=1.
//   - Rst asserted mid-stream: the next edge clears the outputs. The first
//     valid result comes 1 edge after rst deasserts.
//   - Combinational core is purely combinational: no latches, no X for known
//     inputs.
//   - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i);
//     c_0 = c0 port.
// CONFIGURATION
//   - THIRTY_TWO_BITS_FULL_ADDER_OVF_EN defined: adds output port ovf (1 bit),
//     registered with s.
//     ovf <= c_32 ^ c_31 (signed two's-complement overflow); reset value 0.
//   - Macro undefined: no ovf port and no overflow logic. All other behaviour
//     is identical.
// STRUCTURE
//   - Shared package adder_pkg holds ADDER_WIDTH = 32 and typedef word_t
//     (logic [31:0]).
//   - Sub-module full_adder_bit (a, b, cin -> s, cout) is instantiated 32x in a
//     generate loop forming the carry chain.
//   - Top level contains the chain, the output register and the optional
//     overflow logic.
// TESTING
//   1. rst=1 for 2 edges with a=647, b=6100 -> s=0, cout=0.
//      Release rst -> s=6747 after 1 edge.
//   2. a=6100, b=7, c0=1 -> s=6108, cout=0. Then a=15, b=15, c0=1 -> s=31.
//   3. Back-to-back each cycle: (1,1)->2, (2,1)->3, (9,8)->17, (12,10)->22,
//      (13,1)->14, all c0=0. Each result appears exactly 1 cycle later.
//   4. a=0xFFFFFFFF, b=0, c0=1 -> s=0, cout=1.
//      Then a=0x80000000, b=0x80000000 -> s=0, cout=1.
//   5. OVF_EN: a=0x7FFFFFFF, b=1 -> s=0x80000000, ovf=1, cout=0.
//      Then a=5, b=1 -> ovf=0.
//   6. Assert rst while streaming (9,9) -> next edge gives s=0.
//      Deassert -> s=18 after 1 edge. Random compare vs a+b+c0, 1000 vectors.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the 32-bit ripple-carry adder.
// Holds the datapath width and the word type used by the adder and its users.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; 32 of these are chained to form the ripple-carry adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    // Generate when both operands are set, propagate an incoming carry otherwise.
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_bit

// File: rtl/thirty_two_bits_full_adder.sv
// Registered 32-bit ripple-carry adder: {cout,s} <= a + b + c0, one cycle latency.
// Define THIRTY_TWO_BITS_FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module thirty_two_bits_full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
`ifdef THIRTY_TWO_BITS_FULL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = c0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum_comb;
            cout <= carry[WIDTH];
        end
    end

`ifdef THIRTY_TWO_BITS_FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule : thirty_two_bits_full_adder

// File: tb/tb_thirty_two_bits_full_adder.sv
// Self-checking bench for thirty_two_bits_full_adder: directed vector table,
// mid-stream reset sequence and a randomised comparison against a + b + c0.
module tb_thirty_two_bits_full_adder;
    import adder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    word_t a;
    word_t b;
    logic  c0;
    word_t s;
    logic  cout;
    logic  ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    thirty_two_bits_full_adder dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c0   (c0),
        .s    (s),
`ifdef THIRTY_TWO_BITS_FULL_ADDER_OVF_EN
        .cout (cout),
        .ovf  (ovf)
`else
        .cout (cout)
`endif
    );

`ifndef THIRTY_TWO_BITS_FULL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    typedef struct {
        logic  rst;
        word_t a;
        word_t b;
        logic  c0;
        word_t exp_s;
        logic  exp_cout;
        logic  exp_ovf;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input word_t es, input logic ec, input logic eo);
        check({tag, ".s"}, 64'(s), 64'(es));
        check({tag, ".cout"}, 64'(cout), 64'(ec));
`ifdef THIRTY_TWO_BITS_FULL_ADDER_OVF_EN
        check({tag, ".ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo !== eo) check({tag, ".ovf"}, 64'(ovf), 64'(eo));
`endif
    endtask

    task automatic drive(input logic r, input word_t aa, input word_t bb, input logic cc);
        rst = r;
        a   = aa;
        b   = bb;
        c0  = cc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst a b c0 | s cout ovf
        vecs[0]  = '{1'b1, 32'd647,        32'd6100,       1'b0, 32'd0,          1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'd647,        32'd6100,       1'b0, 32'd0,          1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'd647,        32'd6100,       1'b0, 32'd6747,       1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'd6100,       32'd7,          1'b1, 32'd6108,       1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'd15,         32'd15,         1'b1, 32'd31,         1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'd1,          32'd1,          1'b0, 32'd2,          1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'd2,          32'd1,          1'b0, 32'd3,          1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'd9,          32'd8,          1'b0, 32'd17,         1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'd12,         32'd10,         1'b0, 32'd22,         1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'd13,         32'd1,          1'b0, 32'd14,         1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'h0,          1'b1, 32'h0,          1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0,          1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'h7FFF_FFFF,  32'h1,          1'b0, 32'h8000_0000,  1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'd5,          32'd1,          1'b0, 32'd6,          1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[15] = '{1'b0, 32'hAAAA_AAAA,  32'h5555_5555,  1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0};

        drive(1'b1, 32'd0, 32'd0, 1'b0);

        // Each row's result must not show before the edge and must show right after it.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c0);
            if (i > 0) begin
                @(negedge clk);
                check($sformatf("hold[%0d].s", i), 64'(s), 64'(vecs[i-1].exp_s));
            end
            step();
            check_out($sformatf("vec[%0d]", i), vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Reset asserted while streaming (9,9).
        drive(1'b0, 32'd9, 32'd9, 1'b0);
        step();
        check_out("stream9.a", 32'd18, 1'b0, 1'b0);
        step();
        check_out("stream9.b", 32'd18, 1'b0, 1'b0);
        drive(1'b1, 32'd9, 32'd9, 1'b0);
        step();
        check_out("midrst", 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        check("postrst.hold.s", 64'(s), 64'd0);
        step();
        check_out("postrst", 32'd18, 1'b0, 1'b0);

        // Randomised comparison against an exact 33-bit sum.
        for (int i = 0; i < 1000; i++) begin
            word_t       ra;
            word_t       rb;
            logic        rc;
            logic [32:0] full;
            logic        rovf;
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            if (i % 16 == 0) ra = 32'hFFFF_FFFF;
            if (i % 16 == 1) rb = 32'h8000_0000;
            full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            rovf = (ra[31] == rb[31]) && (full[31] != ra[31]);
            drive(1'b0, ra, rb, rc);
            step();
            check_out($sformatf("rand[%0d]", i), full[31:0], full[32], rovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_thirty_two_bits_full_adder
